mod_counter: RTL and testbench



---
 rtl/mod_counter.sv | 103 ++++++++++
 tb/tb_mod_counter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Modulo-N time-field counter with up/down counting, validated parallel load,
// registered wrap carry, registered BCD digits and an enable-gated read-back bus.
module mod_counter #(
  parameter int WIDTH     = 6,
  parameter int MODULUS   = 60,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             tick,
  input  logic             up_down,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] databus,
  output logic             carry,
  output logic             load_err,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
);

  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MOD_MAX   = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);
  localparam logic [3:0]       RST_TENS  = 4'(RESET_VAL / 10);
  localparam logic [3:0]       RST_ONES  = 4'(RESET_VAL % 10);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             load_err_q, load_err_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   data_ext;
  logic [7:0]       next_wide;

  assign count_ext = {1'b0, count_q};
  assign data_ext  = {1'b0, data};

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    count_d    = count_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (data_ext < MOD_EXT) count_d = data;
      else                    load_err_d = 1'b1;
    end else if (tick) begin
      // Wrap is found by comparison against the range ends, never by overflow;
      // an out-of-range value self-corrects to zero without a carry.
      if (count_ext >= MOD_EXT) begin
        count_d = '0;
      end else if (up_down) begin
        if (count_ext == MOD_MAX) begin
          count_d = '0;
          carry_d = 1'b1;
        end else begin
          count_d = WIDTH'(count_ext + 1'b1);
        end
      end else begin
        if (count_ext == '0) begin
          count_d = MOD_MAX[WIDTH-1:0];
          carry_d = 1'b1;
        end else begin
          count_d = WIDTH'(count_ext - 1'b1);
        end
      end
    end
  end

  // Digits come from the next value so they land on the same edge as count.
  assign next_wide = 8'(count_d);
  assign tens_d    = 4'(next_wide / 8'd10);
  assign ones_d    = 4'(next_wide % 8'd10);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count_q    <= RST_COUNT;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
      tens_q     <= RST_TENS;
      ones_q     <= RST_ONES;
    end else begin
      count_q    <= count_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
    end
  end

  assign count    = count_q;
  assign carry    = carry_q;
  assign load_err = load_err_q;
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;
  assign databus  = count_q & {WIDTH{enable}};

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: seconds (mod 60), hours (mod 24) and a
// minutes stage cascaded from the seconds stage, checked against a modular-arithmetic model.
module tb_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear_n;

  // Seconds stage, MODULUS 60
  logic       ld_s, tk_s, ud_s, en_s;
  logic [5:0] dat_s, cnt_s, db_s;
  logic       car_s, err_s;
  logic [3:0] bt_s, bo_s;

  // Hours-style stage, MODULUS 24, non-zero reset value
  logic       ld_h, tk_h, ud_h, en_h;
  logic [4:0] dat_h, cnt_h, db_h;
  logic       car_h, err_h;
  logic [3:0] bt_h, bo_h;

  // Minutes stage, optionally advanced by the seconds stage
  logic       ld_m, tk_m, ud_m, en_m, cascade;
  logic [5:0] dat_m, cnt_m, db_m;
  logic       car_m, err_m;
  logic [3:0] bt_m, bo_m;
  logic       tick_m;

  // Lookahead cascade: minutes step on the same edge the seconds stage wraps.
  assign tick_m = cascade ? (tk_s & ~ld_s & (ud_s ? (cnt_s == 6'd59) : (cnt_s == 6'd0)))
                          : tk_m;

  mod_counter #(.WIDTH(6), .MODULUS(60), .RESET_VAL(0)) u_sec (
    .clk(clk), .clear_n(clear_n), .load(ld_s), .data(dat_s), .tick(tk_s),
    .up_down(ud_s), .enable(en_s), .count(cnt_s), .databus(db_s), .carry(car_s),
    .load_err(err_s), .bcd_tens(bt_s), .bcd_ones(bo_s));

  mod_counter #(.WIDTH(5), .MODULUS(24), .RESET_VAL(5)) u_hr (
    .clk(clk), .clear_n(clear_n), .load(ld_h), .data(dat_h), .tick(tk_h),
    .up_down(ud_h), .enable(en_h), .count(cnt_h), .databus(db_h), .carry(car_h),
    .load_err(err_h), .bcd_tens(bt_h), .bcd_ones(bo_h));

  mod_counter #(.WIDTH(6), .MODULUS(60), .RESET_VAL(0)) u_min (
    .clk(clk), .clear_n(clear_n), .load(ld_m), .data(dat_m), .tick(tick_m),
    .up_down(ud_m), .enable(en_m), .count(cnt_m), .databus(db_m), .carry(car_m),
    .load_err(err_m), .bcd_tens(bt_m), .bcd_ones(bo_m));

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: index 0 seconds, 1 hours, 2 minutes
  int m_cnt [3];
  int m_car [3];
  int m_err [3];
  int m_mod [3] = '{60, 24, 60};
  int m_rst [3] = '{0, 5, 0};

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    vectors++;
    assert (obs === 32'(exp)) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void step(input int k, input bit clr, input bit ld, input int d,
                               input bit tk, input bit up);
    if (!clr) begin
      m_cnt[k] = m_rst[k]; m_car[k] = 0; m_err[k] = 0;
    end else if (ld) begin
      m_car[k] = 0;
      if (d < m_mod[k]) begin m_cnt[k] = d; m_err[k] = 0; end
      else m_err[k] = 1;
    end else if (tk) begin
      m_err[k] = 0;
      if (up) begin
        m_car[k] = (m_cnt[k] == m_mod[k] - 1) ? 1 : 0;
        m_cnt[k] = (m_cnt[k] + 1) % m_mod[k];
      end else begin
        m_car[k] = (m_cnt[k] == 0) ? 1 : 0;
        m_cnt[k] = (m_cnt[k] + m_mod[k] - 1) % m_mod[k];
      end
    end else begin
      m_car[k] = 0; m_err[k] = 0;
    end
  endfunction

  task automatic check_dut(input string n, input int k, input logic [31:0] cnt,
                           input logic car, input logic err, input logic [3:0] bt,
                           input logic [3:0] bo, input logic [31:0] db, input logic en);
    check({n, ".count"},    cnt,        m_cnt[k]);
    check({n, ".carry"},    32'(car),   m_car[k]);
    check({n, ".load_err"}, 32'(err),   m_err[k]);
    check({n, ".bcd_tens"}, 32'(bt),    m_cnt[k] / 10);
    check({n, ".bcd_ones"}, 32'(bo),    m_cnt[k] % 10);
    check({n, ".databus"},  db,         en ? m_cnt[k] : 0);
  endtask

  task automatic check_all();
    check_dut("sec", 0, 32'(cnt_s), car_s, err_s, bt_s, bo_s, 32'(db_s), en_s);
    check_dut("hr",  1, 32'(cnt_h), car_h, err_h, bt_h, bo_h, 32'(db_h), en_h);
    check_dut("min", 2, 32'(cnt_m), car_m, err_m, bt_m, bo_m, 32'(db_m), en_m);
  endtask

  // Advance the model by one edge using the inputs currently driven, then
  // clock the DUTs and compare on the falling edge.
  task automatic cycle();
    bit mt;
    mt = cascade ? (tk_s && !ld_s && (ud_s ? (m_cnt[0] == 59) : (m_cnt[0] == 0))) : tk_m;
    step(0, clear_n, ld_s, int'(dat_s), tk_s, ud_s);
    step(1, clear_n, ld_h, int'(dat_h), tk_h, ud_h);
    step(2, clear_n, ld_m, int'(dat_m), mt,   ud_m);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    clear_n = 1'b0; cascade = 1'b0;
    ld_s = 0; tk_s = 0; ud_s = 1; en_s = 0; dat_s = '0;
    ld_h = 0; tk_h = 0; ud_h = 1; en_h = 0; dat_h = '0;
    ld_m = 0; tk_m = 0; ud_m = 1; en_m = 0; dat_m = '0;
    m_cnt = '{0, 0, 0}; m_car = '{0, 0, 0}; m_err = '{0, 0, 0};
    @(negedge clk);

    // Reset held two cycles, databus checked with enable low then high
    cycle(); cycle();
    en_s = 1; en_h = 1; en_m = 1; #1;
    check_all();
    clear_n = 1'b1;

    // Up-wrap on seconds: 58 -> 59, 0 (carry), 1
    ld_s = 1; dat_s = 6'd58; cycle();
    ld_s = 0; tk_s = 1; ud_s = 1;
    repeat (3) cycle();
    tk_s = 0;

    // Down-wrap on the mod-24 stage: 1 -> 0, 23 (borrow), 22
    ld_h = 1; dat_h = 5'd1; cycle();
    ld_h = 0; tk_h = 1; ud_h = 0;
    repeat (3) cycle();
    tk_h = 0;

    // Rejected loads hold the count and pulse load_err; a tick alongside is ignored
    ld_s = 1; dat_s = 6'd17; cycle();
    dat_s = 6'd60; tk_s = 1; ld_h = 1; dat_h = 5'd24; cycle();
    dat_s = 6'd59; tk_s = 0; dat_h = 5'd31; cycle();
    ld_h = 0; cycle();

    // Load beats a pending wrap; reset beats a tick
    dat_s = 6'd30; tk_s = 1; ud_s = 1; cycle();
    ld_s = 0; clear_n = 1'b0; tk_h = 1; cycle();
    clear_n = 1'b1; tk_s = 0; tk_h = 0;

    // Cascade 59:59 -> 00:00 with both carries on the same cycle
    cascade = 1;
    ld_s = 1; dat_s = 6'd59; ld_m = 1; dat_m = 6'd59; cycle();
    ld_s = 0; ld_m = 0; tk_s = 1; ud_s = 1; ud_m = 1; cycle();
    en_m = 0; #1;
    check_all();
    tk_s = 0; cycle();

    // Randomised traffic through all three stages with the cascade active
    for (int i = 0; i < 400; i++) begin
      clear_n = ($urandom_range(0, 49) != 0);
      ld_s = ($urandom_range(0, 5) == 0); dat_s = 6'($urandom);
      tk_s = ($urandom_range(0, 2) != 0); ud_s = 1'($urandom); en_s = 1'($urandom);
      ld_h = ($urandom_range(0, 5) == 0); dat_h = 5'($urandom);
      tk_h = ($urandom_range(0, 2) != 0); ud_h = 1'($urandom); en_h = 1'($urandom);
      ld_m = ($urandom_range(0, 9) == 0); dat_m = 6'($urandom);
      ud_m = ud_s; en_m = 1'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
